// File: rtl/mb_fetch_ctrl_if.sv
// AXI read-address channel plus R-channel monitor taps for the macroblock fetch sequencer.
// The master drives the AR channel; the R signals are only observed.
interface mb_fetch_ctrl_if #(
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned ADDR_W   = 64
);
  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [7:0]          m_axi_arlen;
  logic [2:0]          m_axi_arsize;
  logic [1:0]          m_axi_arburst;
  logic [ID_WIDTH-1:0] m_axi_arid;
  logic                m_axi_arvalid;
  logic                m_axi_arready;
  logic                m_axi_rvalid;
  logic                m_axi_rready;
  logic                m_axi_rlast;
  logic [1:0]          m_axi_rresp;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arvalid,
    input  m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast, m_axi_rresp
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arvalid,
    output m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast, m_axi_rresp
  );
endinterface

// File: rtl/mb_fetch_ctrl.sv
// Read-address sequencer: one 3-beat x 1024-bit INCR burst per macroblock, credit-limited
// against the Y0/Y1/UV FIFO depth, with R-channel completion counting for done/error.
module mb_fetch_ctrl #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned MB_STRIDE = 512,
  parameter int unsigned CREDITS   = 8,
  parameter int unsigned AR_ID     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pulse,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       mb_total,
  input  logic              mb_pop,
  mb_fetch_ctrl_if.master   axi,
  output logic              busy,
  output logic              done,
  output logic              rd_error
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(MB_STRIDE);
  localparam logic [CW-1:0]     CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_n;
  logic              arvalid_q, arvalid_n;
  logic [ADDR_W-1:0] araddr_q, araddr_n;
  logic [15:0]       issued_q, issued_n;
  logic [15:0]       cmpl_q, cmpl_n;
  logic [15:0]       total_q, total_n;
  logic [CW-1:0]     credit_q, credit_n;
  logic              busy_n, done_n, rd_error_n;
  logic              ar_hs, r_hs, pop_ok, credit_free;

  // Burst shape is fixed: 3 beats of 128 B, incrementing.
  assign axi.m_axi_arlen   = 8'd2;
  assign axi.m_axi_arsize  = 3'd7;
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arid    = ID_WIDTH'(AR_ID);
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_araddr  = araddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      issued_q  <= '0;
      cmpl_q    <= '0;
      total_q   <= '0;
      credit_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_error  <= 1'b0;
    end else begin
      state     <= state_n;
      arvalid_q <= arvalid_n;
      araddr_q  <= araddr_n;
      issued_q  <= issued_n;
      cmpl_q    <= cmpl_n;
      total_q   <= total_n;
      credit_q  <= credit_n;
      busy      <= busy_n;
      done      <= done_n;
      rd_error  <= rd_error_n;
    end
  end

  always_comb begin
    state_n     = state;
    arvalid_n   = arvalid_q;
    araddr_n    = araddr_q;
    issued_n    = issued_q;
    cmpl_n      = cmpl_q;
    total_n     = total_q;
    credit_n    = credit_q;
    rd_error_n  = rd_error;
    ar_hs       = arvalid_q & axi.m_axi_arready;
    r_hs        = axi.m_axi_rvalid & axi.m_axi_rready;
    pop_ok      = mb_pop && (credit_q != '0);

    // Issue and pop in the same cycle cancel; a pop with nothing outstanding is dropped.
    if (ar_hs && !pop_ok) begin
      credit_n = credit_q + CW'(1);
    end else if (!ar_hs && pop_ok) begin
      credit_n = credit_q - CW'(1);
    end
    credit_free = (credit_n < CRED_MAX);

    if (state != S_IDLE) begin
      if (r_hs && axi.m_axi_rlast) begin
        cmpl_n = cmpl_q + 16'd1;
      end
      if (r_hs && (axi.m_axi_rresp != 2'b00)) begin
        rd_error_n = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        if (start_pulse) begin
          total_n    = mb_total;
          issued_n   = 16'd0;
          cmpl_n     = 16'd0;
          rd_error_n = 1'b0;
          araddr_n   = base_addr;
          if (mb_total != 16'd0) begin
            state_n   = S_ISSUE;
            arvalid_n = credit_free;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        // A pending request holds address and valid until it is accepted.
        if (ar_hs) begin
          araddr_n = araddr_q + STRIDE;
          issued_n = issued_q + 16'd1;
          if (issued_n == total_q) begin
            state_n   = S_DRAIN;
            arvalid_n = 1'b0;
          end else begin
            arvalid_n = credit_free;
          end
        end else if (!arvalid_q) begin
          arvalid_n = credit_free;
        end
      end
      S_DRAIN: begin
        if (cmpl_n >= total_q) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
    done_n = (state == S_DONE);
  end

endmodule
